// File: rtl/hwpe_job_launcher_pkg.sv
// Shared constants for the HWPE job launcher: FSM encodings, accelerator
// register offsets and the refused-acquire flag position.
package hwpe_job_launcher_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_ACQ_REQ  = 3'd1;
    localparam logic [STATE_W-1:0] ST_ACQ_RSP  = 3'd2;
    localparam logic [STATE_W-1:0] ST_BACKOFF  = 3'd3;
    localparam logic [STATE_W-1:0] ST_WR_REG   = 3'd4;
    localparam logic [STATE_W-1:0] ST_TRIG     = 3'd5;
    localparam logic [STATE_W-1:0] ST_WAIT_EVT = 3'd6;
    localparam logic [STATE_W-1:0] ST_DONE     = 3'd7;

    localparam logic [31:0] OFS_TRIGGER      = 32'h0000_0000;
    localparam logic [31:0] OFS_ACQUIRE      = 32'h0000_0004;
    localparam logic [31:0] OFS_JOB_REG_BASE = 32'h0000_0040;

    localparam int unsigned ACQUIRE_REFUSED_BIT = 31;

    // Byte offset of job register k relative to the accelerator base.
    function automatic logic [31:0] job_reg_ofs(input logic [3:0] k);
        return OFS_JOB_REG_BASE + {26'd0, k, 2'b00};
    endfunction

endpackage

// File: rtl/hwpe_job_launcher.sv
// Peripheral-bus master that acquires an HWPE context, programs the job
// registers, triggers and waits for completion. Optional: HWPE_JOB_LAUNCHER_TIMEOUT_EN.
module hwpe_job_launcher
    import hwpe_job_launcher_pkg::*;
#(
    parameter int unsigned N_JOB_REGS  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ID_WIDTH    = 16,
    parameter int unsigned MASTER_ID   = 0,
    parameter int unsigned RETRY_DELAY = 8
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65536
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [N_JOB_REGS*32-1:0] job_regs_i,
    output logic                    done_o,
    output logic [7:0]              job_id_o,
    output logic                    busy_o,
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
    output logic                    error_o,
`endif
    input  logic                    evt_i,
    output logic                    periph_req_o,
    input  logic                    periph_gnt_i,
    output logic [31:0]             periph_add_o,
    output logic                    periph_wen_o,
    output logic [3:0]              periph_be_o,
    output logic [31:0]             periph_data_o,
    output logic [ID_WIDTH-1:0]     periph_id_o,
    input  logic [31:0]             periph_r_data_i,
    input  logic                    periph_r_valid_i,
    input  logic [ID_WIDTH-1:0]     periph_r_id_i
);

    localparam int unsigned IDX_W = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
    localparam int unsigned BO_W  = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BO_W-1:0]    bo_cnt_q, bo_cnt_d;
    logic [7:0]         job_id_q, job_id_d;
    logic               evt_seen_q, evt_seen_d;
    logic [31:0]        regs_q [N_JOB_REGS];
    logic [31:0]        regs_d [N_JOB_REGS];

    logic               req_q, req_d;
    logic [31:0]        add_q, add_d;
    logic               wen_q, wen_d;
    logic [31:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
    logic [31:0]        tmo_cnt_q, tmo_cnt_d;
    logic               error_q, error_d;
`endif

    logic               xfer;
    logic               rsp_ok;
    logic               unused_rdata;

    assign xfer         = req_q & periph_gnt_i;
    assign rsp_ok       = periph_r_valid_i & (periph_r_id_i == ID_WIDTH'(MASTER_ID));
    assign unused_rdata = ^periph_r_data_i[30:8];

    // Next-state logic plus the bus/status values that go with the next state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bo_cnt_d   = bo_cnt_q;
        job_id_d   = job_id_q;
        evt_seen_d = evt_seen_q;
        regs_d     = regs_q;
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        error_d    = error_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (job_valid_i) begin
                    for (int unsigned k = 0; k < N_JOB_REGS; k++) begin
                        regs_d[k] = job_regs_i[32*k +: 32];
                    end
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    state_d = ST_ACQ_REQ;
                end
            end
            ST_ACQ_REQ: begin
                if (xfer) state_d = ST_ACQ_RSP;
            end
            ST_ACQ_RSP: begin
                if (rsp_ok) begin
                    if (periph_r_data_i[ACQUIRE_REFUSED_BIT]) begin
                        bo_cnt_d = '0;
                        state_d  = ST_BACKOFF;
                    end else begin
                        job_id_d = periph_r_data_i[7:0];
                        idx_d    = '0;
                        state_d  = ST_WR_REG;
                    end
                end
            end
            ST_BACKOFF: begin
                if (bo_cnt_q == BO_W'(RETRY_DELAY - 1)) begin
                    state_d = ST_ACQ_REQ;
                end else begin
                    bo_cnt_d = bo_cnt_q + BO_W'(1);
                end
            end
            ST_WR_REG: begin
                if (xfer) begin
                    if (idx_q == IDX_W'(N_JOB_REGS - 1)) begin
                        state_d = ST_TRIG;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_TRIG: begin
                // An event coincident with the trigger grant must not be lost.
                if (xfer) begin
                    evt_seen_d = evt_i;
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
                    tmo_cnt_d  = 32'd1;
`endif
                    state_d    = ST_WAIT_EVT;
                end
            end
            ST_WAIT_EVT: begin
                if (evt_seen_q | evt_i) begin
                    state_d = ST_DONE;
                end
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                    if (tmo_cnt_d == 32'(TIMEOUT_CYCLES)) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
`endif
            end
            ST_DONE: begin
                evt_seen_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_d  = 1'b0;
        add_d  = 32'd0;
        wen_d  = 1'b1;
        data_d = 32'd0;
        case (state_d)
            ST_ACQ_REQ: begin
                req_d = 1'b1;
                add_d = BASE_ADDR + OFS_ACQUIRE;
                wen_d = 1'b1;
            end
            ST_WR_REG: begin
                req_d  = 1'b1;
                add_d  = BASE_ADDR + job_reg_ofs(4'(idx_d));
                wen_d  = 1'b0;
                data_d = regs_q[idx_d];
            end
            ST_TRIG: begin
                req_d = 1'b1;
                add_d = BASE_ADDR + OFS_TRIGGER;
                wen_d = 1'b0;
            end
            default: ;
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            bo_cnt_q   <= '0;
            job_id_q   <= 8'd0;
            evt_seen_q <= 1'b0;
            for (int unsigned k = 0; k < N_JOB_REGS; k++) regs_q[k] <= 32'd0;
            req_q      <= 1'b0;
            add_q      <= 32'd0;
            wen_q      <= 1'b1;
            data_q     <= 32'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
            tmo_cnt_q  <= 32'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bo_cnt_q   <= bo_cnt_d;
            job_id_q   <= job_id_d;
            evt_seen_q <= evt_seen_d;
            regs_q     <= regs_d;
            req_q      <= req_d;
            add_q      <= add_d;
            wen_q      <= wen_d;
            data_q     <= data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            error_q    <= error_d;
`endif
        end
    end

    assign job_ready_o   = ready_q;
    assign done_o        = done_q;
    assign busy_o        = busy_q;
    assign job_id_o      = job_id_q;
    assign periph_req_o  = req_q;
    assign periph_add_o  = add_q;
    assign periph_wen_o  = wen_q;
    assign periph_data_o = data_q;
    assign periph_be_o   = 4'hF;
    assign periph_id_o   = ID_WIDTH'(MASTER_ID);
`ifdef HWPE_JOB_LAUNCHER_TIMEOUT_EN
    assign error_o       = error_q;
`endif

endmodule
